// File: rtl/window3x3_filter_if.sv
// Pixel stream bundle for the 3x3 neighbourhood filter: kernel controls,
// input beat and filtered output beat with frame status pulses.
interface window3x3_filter_if #(parameter int PIX_W = 8);
  logic [2:0]       mode;
  logic [PIX_W-1:0] thresh;
  logic             in_valid;
  logic [PIX_W-1:0] in_pix;
  logic             in_sof;
  logic             out_valid;
  logic [PIX_W-1:0] out_pix;
  logic             out_sof;
  logic             frame_done;
  logic             short_frame;

  modport master (
    output mode, thresh, in_valid, in_pix, in_sof,
    input  out_valid, out_pix, out_sof, frame_done, short_frame
  );

  modport slave (
    input  mode, thresh, in_valid, in_pix, in_sof,
    output out_valid, out_pix, out_sof, frame_done, short_frame
  );
endinterface

// File: rtl/window3x3_filter.sv
// Streaming 3x3 filter: two line buffers build the window, then a two-stage
// pipeline (window sums, then normalise/saturate/threshold) emits one pixel per beat.
module window3x3_filter #(
  parameter int PIX_W = 8,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input logic               pclk,
  input logic               rst_n,
  window3x3_filter_if.slave bus
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  // Wide enough for the 16x Gaussian sum as a signed value.
  localparam int W  = PIX_W + 6;
  localparam logic [PIX_W-1:0] MAX = '1;

  typedef enum logic {IDLE, RUN} state_t;

  function automatic logic signed [W-1:0] ext(input logic [PIX_W-1:0] p);
    return $signed({{(W-PIX_W){1'b0}}, p});
  endfunction

  function automatic logic [PIX_W-1:0] sat(input logic signed [W-1:0] x);
    if (x < 0)             return '0;
    else if (x > ext(MAX)) return MAX;
    else                   return x[PIX_W-1:0];
  endfunction

  state_t           state_q;
  logic [CW-1:0]    col_q, col_d, beat_col;
  logic [RW-1:0]    row_q, row_d, beat_row;
  logic             accept, last_beat;
  logic [2:0]       mode_q, mode_eff;
  logic [PIX_W-1:0] thresh_q, thresh_eff;

  always_comb begin
    accept     = bus.in_valid && (state_q == RUN || bus.in_sof);
    beat_col   = bus.in_sof ? '0 : col_q;
    beat_row   = bus.in_sof ? '0 : row_q;
    mode_eff   = bus.in_sof ? bus.mode : mode_q;
    thresh_eff = bus.in_sof ? bus.thresh : thresh_q;
    last_beat  = accept && beat_row == RW'(IMG_H-1) && beat_col == CW'(IMG_W-1);
    col_d      = col_q;
    row_d      = row_q;
    if (accept) begin
      if (beat_col == CW'(IMG_W-1)) begin
        col_d = '0;
        row_d = (beat_row == RW'(IMG_H-1)) ? '0 : beat_row + 1'b1;
      end else begin
        col_d = beat_col + 1'b1;
        row_d = beat_row;
      end
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      col_q    <= '0;
      row_q    <= '0;
      mode_q   <= '0;
      thresh_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      if (accept && bus.in_sof) begin
        mode_q   <= bus.mode;
        thresh_q <= bus.thresh;
      end
      if (last_beat)   state_q <= IDLE;
      else if (accept) state_q <= RUN;
    end
  end

  // Read address is the column of the next beat, so the registered read is ready for it.
  logic [PIX_W-1:0] lb_a_mem [IMG_W];
  logic [PIX_W-1:0] lb_b_mem [IMG_W];
  logic [PIX_W-1:0] rd_a_q, rd_b_q;

  always_ff @(posedge pclk) begin
    if (accept) begin
      lb_a_mem[beat_col] <= bus.in_pix;
      lb_b_mem[beat_col] <= rd_a_q;
    end
    rd_a_q <= lb_a_mem[col_d];
    rd_b_q <= lb_b_mem[col_d];
  end

  // win_q[row][col]: row 0 = r-2 (north), col 0 = newest column c (east).
  logic [PIX_W-1:0] win_q [3][3];
  logic             v0_q, sof0_q, last0_q, short0_q, bord0_q, edge0_q;
  logic [2:0]       mode0_q;
  logic [PIX_W-1:0] thr0_q;

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++) win_q[i][j] <= '0;
      {v0_q, sof0_q, last0_q, short0_q, bord0_q, edge0_q} <= '0;
      mode0_q <= '0;
      thr0_q  <= '0;
    end else begin
      v0_q <= accept;
      if (accept) begin
        for (int i = 0; i < 3; i++) begin
          win_q[i][2] <= win_q[i][1];
          win_q[i][1] <= win_q[i][0];
        end
        win_q[0][0] <= rd_b_q;
        win_q[1][0] <= rd_a_q;
        win_q[2][0] <= bus.in_pix;
        sof0_q   <= bus.in_sof;
        last0_q  <= last_beat;
        short0_q <= bus.in_sof && state_q == RUN;
        bord0_q  <= beat_row < RW'(2) || beat_col < CW'(2);
        edge0_q  <= beat_row == '0 || beat_col == '0;
        mode0_q  <= mode_eff;
        thr0_q   <= thresh_eff;
      end
    end
  end

  logic signed [W-1:0] gauss_s, gx_s, gy_s, sob_s, sharp_s;

  always_comb begin
    gauss_s = ext(win_q[0][2]) + ext(win_q[0][0]) + ext(win_q[2][2]) + ext(win_q[2][0])
            + ((ext(win_q[0][1]) + ext(win_q[2][1]) + ext(win_q[1][0]) + ext(win_q[1][2])) <<< 1)
            + (ext(win_q[1][1]) <<< 2);
    gx_s    = (ext(win_q[0][0]) + (ext(win_q[1][0]) <<< 1) + ext(win_q[2][0]))
            - (ext(win_q[0][2]) + (ext(win_q[1][2]) <<< 1) + ext(win_q[2][2]));
    gy_s    = (ext(win_q[2][2]) + (ext(win_q[2][1]) <<< 1) + ext(win_q[2][0]))
            - (ext(win_q[0][2]) + (ext(win_q[0][1]) <<< 1) + ext(win_q[0][0]));
    sob_s   = (gx_s < 0 ? -gx_s : gx_s) + (gy_s < 0 ? -gy_s : gy_s);
    sharp_s = (ext(win_q[1][1]) <<< 2) + ext(win_q[1][1])
            - ext(win_q[0][1]) - ext(win_q[2][1]) - ext(win_q[1][0]) - ext(win_q[1][2]);
  end

  logic signed [W-1:0] gauss1_q, sob1_q, sharp1_q;
  logic [PIX_W-1:0]    c1_q, thr1_q;
  logic [2:0]          mode1_q;
  logic                v1_q, sof1_q, last1_q, short1_q, bord1_q, edge1_q;

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      {gauss1_q, sob1_q, sharp1_q} <= '0;
      {c1_q, thr1_q, mode1_q}      <= '0;
      {v1_q, sof1_q, last1_q, short1_q, bord1_q, edge1_q} <= '0;
    end else begin
      gauss1_q <= gauss_s >>> 4;
      sob1_q   <= sob_s;
      sharp1_q <= sharp_s;
      c1_q     <= win_q[1][1];
      thr1_q   <= thr0_q;
      mode1_q  <= mode0_q;
      {v1_q, sof1_q, last1_q, short1_q, bord1_q, edge1_q} <=
        {v0_q, sof0_q, last0_q, short0_q, bord0_q, edge0_q};
    end
  end

  logic [PIX_W-1:0] res_d, sob_sat;

  always_comb begin
    sob_sat = sat(sob1_q);
    case (mode1_q)
      3'd1:    res_d = sat(gauss1_q);
      3'd2:    res_d = sob_sat;
      3'd3:    res_d = sat(sharp1_q);
      3'd4:    res_d = (c1_q >= thr1_q) ? MAX : '0;
      3'd5:    res_d = (sob_sat >= thr1_q) ? MAX : '0;
      default: res_d = edge1_q ? '0 : c1_q;
    endcase
    if (mode1_q >= 3'd1 && mode1_q <= 3'd5 && bord1_q) res_d = '0;
  end

  logic             out_valid_q, out_sof_q, frame_done_q, short_frame_q;
  logic [PIX_W-1:0] out_pix_q;

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      {out_valid_q, out_sof_q, frame_done_q, short_frame_q} <= '0;
      out_pix_q <= '0;
    end else begin
      out_valid_q   <= v1_q;
      out_pix_q     <= v1_q ? res_d : '0;
      out_sof_q     <= v1_q && sof1_q;
      frame_done_q  <= v1_q && last1_q;
      short_frame_q <= v1_q && short1_q;
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.out_pix     = out_pix_q;
  assign bus.out_sof     = out_sof_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.short_frame = short_frame_q;
endmodule
